// File: rtl/kmap_sweep.sv
// kmap_sweep: clocked truth-table sweep of the 4-input k_map block.
// Drives minterms 0..15 on A..D, samples Y, and compares against expected.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             request a sweep (accepted only when idle)
//   expected[15:0]    expected truth table, bit i = Y for minterm i
//   Y                 combinational output of k_map
//   A,B,C,D           minterm drive, {A,B,C,D} = idx, A is MSB
//   busy              high while minterms are being swept
//   done              one-cycle pulse when results are valid
//   truth[15:0]       captured truth table
//   pass              truth == expected
//   miss_cnt[4:0]     number of mismatching minterms
//   first_miss[3:0]   lowest mismatching minterm (0 if none)
module kmap_sweep #(
    parameter int unsigned SETTLE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        Y,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic        pass,
    output logic [4:0]  miss_cnt,
    output logic [3:0]  first_miss
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t      state;
    state_t      state_n;
    logic [3:0]  idx;
    logic [3:0]  cnt;
    logic [15:0] exp_q;
    logic        accept;
    logic        sample;
    logic        last;
    logic        miss;

    assign accept = (state == S_IDLE) && start;
    assign sample = (state == S_SWEEP) && (cnt == 4'd0);
    assign last   = sample && (idx == 4'd15);
    assign miss   = (Y != exp_q[idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (start) state_n = S_SWEEP;
            S_SWEEP: if (last) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // idx is cleared on the final sample so A..D read 0 outside the sweep.
    // pass is resolved on the final sample so it is valid alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 4'd0;
            cnt        <= 4'd0;
            exp_q      <= 16'd0;
            truth      <= 16'd0;
            pass       <= 1'b0;
            miss_cnt   <= 5'd0;
            first_miss <= 4'd0;
        end else if (accept) begin
            exp_q      <= expected;
            truth      <= 16'd0;
            pass       <= 1'b0;
            miss_cnt   <= 5'd0;
            first_miss <= 4'd0;
            idx        <= 4'd0;
            cnt        <= SETTLE_C;
        end else if (state == S_SWEEP) begin
            if (!sample) begin
                cnt <= cnt - 4'd1;
            end else begin
                truth[idx] <= Y;
                if (miss) begin
                    miss_cnt <= miss_cnt + 5'd1;
                    if (miss_cnt == 5'd0) first_miss <= idx;
                end
                if (last) begin
                    idx  <= 4'd0;
                    pass <= (miss_cnt == 5'd0) && !miss;
                end else begin
                    idx <= idx + 4'd1;
                    cnt <= SETTLE_C;
                end
            end
        end
    end

    assign {A, B, C, D} = idx;
    assign busy = (state == S_SWEEP);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_kmap_sweep.sv
// tb_kmap_sweep: directed bench for kmap_sweep at SETTLE 0 and 2.
// A timeline model per instance is checked against the DUT every cycle.
module tb_kmap_sweep;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        corrupt;
    logic        start_v [2];
    logic [15:0] exp_v   [2];
    logic        y_v     [2];
    logic        a_v     [2];
    logic        b_v     [2];
    logic        c_v     [2];
    logic        d_v     [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic        pass_v  [2];
    logic [15:0] truth_v [2];
    logic [4:0]  miss_v  [2];
    logic [3:0]  first_v [2];

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    // Reference k_map: Y = A'B' + CD'
    function automatic logic kmap_fn(input logic [3:0] m);
        return (!m[3] && !m[2]) || (m[1] && !m[0]);
    endfunction

    function automatic logic [15:0] kmap_tt();
        logic [15:0] tt;
        tt = 16'd0;
        for (int i = 0; i < 16; i++) tt[i] = kmap_fn(4'(i));
        return tt;
    endfunction

    function automatic int lowest_bit(input logic [15:0] v);
        int f;
        f = 0;
        for (int i = 15; i >= 0; i--) if (v[i]) f = i;
        return f;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int S = 2 * g;
        localparam int L = 16 * (S + 1) + 1;

        // t = cycle number since acceptance (1 = first cycle), 0 when idle
        int          t;
        logic [15:0] m_exp;
        logic [15:0] r_truth;
        logic        r_pass;
        int          r_miss;
        int          r_first;

        kmap_sweep #(.SETTLE(S)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start_v[g]),
            .expected  (exp_v[g]),
            .Y         (y_v[g]),
            .A         (a_v[g]),
            .B         (b_v[g]),
            .C         (c_v[g]),
            .D         (d_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .truth     (truth_v[g]),
            .pass      (pass_v[g]),
            .miss_cnt  (miss_v[g]),
            .first_miss(first_v[g])
        );

        // Y is wrong in every slot cycle except the last when corrupt is set
        assign y_v[g] = kmap_fn({a_v[g], b_v[g], c_v[g], d_v[g]}) ^
                        (corrupt && t >= 1 && t <= L - 1 &&
                         ((t - 1) % (S + 1)) != S);

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                t       <= 0;
                m_exp   <= 16'd0;
                r_truth <= 16'd0;
                r_pass  <= 1'b0;
                r_miss  <= 0;
                r_first <= 0;
            end else if (t == 0) begin
                if (start_v[g]) begin
                    t     <= 1;
                    m_exp <= exp_v[g];
                end
            end else if (t == L) begin
                t <= 0;
            end else begin
                t <= t + 1;
                if (t == L - 1) begin
                    r_truth <= kmap_tt();
                    r_miss  <= $countones(kmap_tt() ^ m_exp);
                    r_first <= lowest_bit(kmap_tt() ^ m_exp);
                    r_pass  <= (kmap_tt() == m_exp);
                end
            end
        end

        always @(negedge clk) begin
            int idx;
            logic act;
            act = (t >= 1) && (t <= L - 1);
            idx = act ? (t - 1) / (S + 1) : 0;
            if (!rst_n) begin
                chk($sformatf("rst_abcd%0d", g),
                    {a_v[g], b_v[g], c_v[g], d_v[g]}, 0);
                chk($sformatf("rst_busy%0d", g), busy_v[g], 0);
                chk($sformatf("rst_done%0d", g), done_v[g], 0);
                chk($sformatf("rst_truth%0d", g), truth_v[g], 0);
                chk($sformatf("rst_pass%0d", g), pass_v[g], 0);
                chk($sformatf("rst_miss%0d", g), miss_v[g], 0);
                chk($sformatf("rst_first%0d", g), first_v[g], 0);
            end else begin
                chk($sformatf("busy%0d", g), busy_v[g], act);
                chk($sformatf("done%0d", g), done_v[g], t == L);
                chk($sformatf("abcd%0d", g),
                    {a_v[g], b_v[g], c_v[g], d_v[g]}, idx);
                if (t == 0 || t == L) begin
                    chk($sformatf("truth%0d", g), truth_v[g], r_truth);
                    chk($sformatf("pass%0d", g), pass_v[g], r_pass);
                    chk($sformatf("miss%0d", g), miss_v[g], r_miss);
                    chk($sformatf("first%0d", g), first_v[g], r_first);
                end
            end
        end
    end

    // Raise start for one edge; returns at the negedge of cycle 1.
    task automatic pulse(input int g, input logic [15:0] e);
        @(negedge clk);
        start_v[g] = 1'b1;
        exp_v[g]   = e;
        @(negedge clk);
        start_v[g] = 1'b0;
    endtask

    // Advance from cycle k until done is seen; bounded.
    task automatic wait_done(input int g, inout int k);
        while (!done_v[g] && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!done_v[g]) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int k;
        int extra;
        rst_n      = 1'b0;
        corrupt    = 1'b0;
        start_v[0] = 1'b1;
        start_v[1] = 1'b1;
        exp_v[0]   = 16'hFFFF;
        exp_v[1]   = 16'hFFFF;
        repeat (4) @(negedge clk);
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        rst_n      = 1'b1;
        repeat (2) @(negedge clk);

        // pass case
        pulse(0, 16'h444F);
        k = 1;
        wait_done(0, k);
        chk("pass_lat", k, 17);
        chk("pass_truth", truth_v[0], 16'h444F);
        chk("pass_pass", pass_v[0], 1);
        chk("pass_miss", miss_v[0], 0);
        chk("pass_first", first_v[0], 0);
        repeat (2) @(negedge clk);

        // mismatch case
        pulse(0, 16'h450B);
        k = 1;
        wait_done(0, k);
        chk("mm_lat", k, 17);
        chk("mm_truth", truth_v[0], 16'h444F);
        chk("mm_pass", pass_v[0], 0);
        chk("mm_miss", miss_v[0], 3);
        chk("mm_first", first_v[0], 2);
        repeat (2) @(negedge clk);

        // settle timing with transiently wrong Y
        corrupt = 1'b1;
        pulse(1, 16'h444F);
        k = 1;
        wait_done(1, k);
        chk("settle_lat", k, 49);
        chk("settle_pass", pass_v[1], 1);
        chk("settle_miss", miss_v[1], 0);
        corrupt = 1'b0;
        repeat (2) @(negedge clk);

        // ignored start and expected changes during sweep
        pulse(0, 16'h444F);
        k = 1;
        repeat (4) begin
            @(negedge clk);
            k++;
        end
        start_v[0] = 1'b1;
        @(negedge clk);
        k++;
        start_v[0] = 1'b0;
        exp_v[0]   = 16'h0000;
        wait_done(0, k);
        chk("ign_lat", k, 17);
        chk("ign_pass", pass_v[0], 1);
        chk("ign_miss", miss_v[0], 0);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_v[0]) extra++;
        end
        chk("ign_single_done", extra, 0);

        // mid-sweep reset at idx 7
        pulse(0, 16'h444F);
        k = 1;
        repeat (7) begin
            @(negedge clk);
            k++;
        end
        chk("mid_idx7", {a_v[0], b_v[0], c_v[0], d_v[0]}, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_abcd", {a_v[0], b_v[0], c_v[0], d_v[0]}, 0);
        chk("mid_async_busy", busy_v[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_idle_busy", busy_v[0], 0);
        pulse(0, 16'h444F);
        k = 1;
        wait_done(0, k);
        chk("mid_lat", k, 17);
        chk("mid_pass", pass_v[0], 1);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
